match_controller: RTL
=====================

Name: match_controller

Overview:
- Sequential successor to the combinational win detector. Owns the scoreboard for N players and runs the match phases: serve countdown, rally, and game over.
- Applies a configurable score limit, a win-by margin, and a hard cap that triggers sudden death.
- Sits between the ball/goal logic, which emits point events, and the display/serve logic, which consumes the scores, serve_ready and the winner.

Parameters:
- N_PLAYERS, 2, number of players/paddles; legal range 2..8.
- SCORE_W, 5, width of each score register in bits.
- SCORE_LIMIT, 15, minimum score needed to win; must be >0.
- WIN_BY, 2, required lead over the best opponent; WIN_BY=1 means first to the limit wins.
- SCORE_CAP, 20, sudden-death cap: the first player to reach it wins regardless of margin. Legal only if SCORE_LIMIT <= SCORE_CAP <= 2**SCORE_W-1.
- SERVE_DELAY, 60, number of cycles spent in SERVE_WAIT before play resumes; 0 is legal.
- PLAYER_W, max(1,$clog2(N_PLAYERS)), derived width of a player index.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- new_game  in  1  single-cycle pulse that starts or restarts a match.
- point_valid  in  1  single-cycle pulse: a point has been scored.
- point_player  in  PLAYER_W  index of the player who scored; sampled only when point_valid=1.
- scores  out  N_PLAYERS*SCORE_W  registered scores; player i occupies [i*SCORE_W +: SCORE_W].
- phase  out  2  current state encoding: IDLE=0, SERVE_WAIT=1, PLAY=2, OVER=3.
- serve_ready  out  1  high exactly while phase==PLAY.
- game_over  out  1  high while phase==OVER.
- game_over_pulse  out  1  one-cycle pulse on the cycle phase first shows OVER.
- winner  out  PLAYER_W  index of the winning player; meaningful only while game_over=1.
- point_ignored  out  1  one-cycle pulse, one cycle after a point_valid that was not applied.

Behaviour:
- Reset (reset_n=0, asynchronous): all scores=0, phase=IDLE, serve counter=0, winner=0. serve_ready, game_over, game_over_pulse and point_ignored all 0.
- All outputs are registered.
- Priority per cycle: new_game beats point_valid. If both arrive together, the point is dropped silently, with no point_ignored pulse.
- new_game (any state): next cycle all scores=0, winner=0, serve counter=SERVE_DELAY, phase=SERVE_WAIT.
- IDLE:
  - Waits for new_game.
  - point_valid -> point_ignored pulse.
- SERVE_WAIT:
  - If counter==0, go to PLAY next cycle; otherwise counter decrements.
  - Minimum dwell is 1 cycle (SERVE_DELAY=0); total dwell is SERVE_DELAY+1 cycles.
  - point_valid -> point_ignored pulse.
- PLAY, on point_valid with point_player < N_PLAYERS:
  - Let s' = score[p]+1 and m = max of scores[j] over all j != p, using pre-increment values.
  - Write s' into scores[p]; it is visible on the next cycle.
  - Win condition: (s' >= SCORE_LIMIT and s' - m >= WIN_BY) or (s' == SCORE_CAP).
  - Win: phase=OVER, winner=p, game_over_pulse=1, all in the same next cycle as the score update.
  - No win: phase=SERVE_WAIT with counter=SERVE_DELAY.
- PLAY, on point_valid with point_player >= N_PLAYERS: no score change, point_ignored pulse, and the phase stays PLAY.
- OVER:
  - Scores and winner are frozen.
  - point_valid -> point_ignored pulse.
  - Only new_game or reset leaves this state.
- Arithmetic: the margin is computed in SCORE_W+1 bits. The subtraction must never wrap; if s' <= m the margin is treated as 0.
- Scores never exceed SCORE_CAP, because reaching the cap always ends the match.
- Reset asserted mid-countdown or mid-match: immediate return to the reset values. No pending point or pulse survives.

Decomposition:
- Package pong_match_pkg holds:
  - typedef enum logic [1:0] match_phase_t {IDLE, SERVE_WAIT, PLAY, OVER};
  - a function computing the default PLAYER_W.
- Sub-module best_opponent (combinational): inputs are the score vector and an excluded index; output is the max of the remaining scores. It is instantiated once, indexed by point_player.
- FSM, counter and score registers live in match_controller.

Test Plan:
- Reset then new_game, SERVE_DELAY=3: phase shows IDLE -> SERVE_WAIT for 4 cycles -> PLAY; serve_ready rises on cycle 5 after new_game; all scores 0.
- Default params, p0 scores 15 vs p1 at 10: after the point, phase=OVER, winner=0, game_over_pulse for exactly 1 cycle; a later point_valid gives point_ignored and scores stay 15/10.
- Deuce, 14/14: p0 scores -> 15/14 and SERVE_WAIT (no win); p0 scores -> 16/14 -> OVER, winner=0. Separately, alternating points from 19/19 -> p1 reaches 20 = SCORE_CAP -> winner=1.
- Simultaneous new_game and point_valid in PLAY at 7/3: scores=0/0, phase=SERVE_WAIT, no point_ignored pulse.
- N_PLAYERS=3, point_player=3 in PLAY: point_ignored pulse, scores unchanged, phase stays PLAY. point_valid during SERVE_WAIT: ignored.
- reset_n pulled low mid-SERVE_WAIT at scores 5/9: outputs return to reset values asynchronously, before the next clk edge; phase=IDLE after release.

Source files
------------

// File: rtl/pong_match_pkg.sv
// Shared types and helpers for the match controller slice.
//   match_phase_t  : externally visible phase encoding (IDLE/SERVE_WAIT/PLAY/OVER)
//   player_w_for() : width of a player index for a given player count (minimum 1)
package pong_match_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_WAIT = 2'd1,
        PLAY       = 2'd2,
        OVER       = 2'd3
    } match_phase_t;

    function automatic int unsigned player_w_for(input int unsigned n_players);
        if (n_players <= 2) return 1;
        return $clog2(n_players);
    endfunction

endpackage

// File: rtl/best_opponent.sv
// Combinational maximum over every score except the excluded player's.
//   scores  : packed score vector, player i at [i*SCORE_W +: SCORE_W]
//   exclude : index of the player left out of the maximum
//   best    : highest remaining score (0 if none)
module best_opponent
    import pong_match_pkg::*;
#(
    parameter int unsigned N_PLAYERS = 2,
    parameter int unsigned SCORE_W   = 5,
    parameter int unsigned PLAYER_W  = player_w_for(N_PLAYERS)
) (
    input  logic [N_PLAYERS*SCORE_W-1:0] scores,
    input  logic [PLAYER_W-1:0]          exclude,
    output logic [SCORE_W-1:0]           best
);

    always_comb begin
        best = '0;
        for (int unsigned j = 0; j < N_PLAYERS; j++) begin
            if ((j != 32'(exclude)) && (scores[j*SCORE_W +: SCORE_W] > best)) begin
                best = scores[j*SCORE_W +: SCORE_W];
            end
        end
    end

endmodule

// File: rtl/match_controller.sv
// Match controller: scoreboard for N players plus the serve/rally/game-over
// phase machine, with score limit, win-by margin and sudden-death cap.
//   clk, reset_n     : clock, asynchronous active-low reset
//   new_game         : pulse, starts/restarts a match (beats point_valid)
//   point_valid      : pulse, point_player has scored
//   point_player     : index of the scoring player
//   scores           : registered scores, player i at [i*SCORE_W +: SCORE_W]
//   phase            : IDLE=0, SERVE_WAIT=1, PLAY=2, OVER=3
//   serve_ready      : high while phase is PLAY
//   game_over        : high while phase is OVER
//   game_over_pulse  : one cycle, first cycle of OVER
//   winner           : winning player, valid while game_over
//   point_ignored    : one cycle, follows a point_valid that was not applied
module match_controller
    import pong_match_pkg::*;
#(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned SCORE_W     = 5,
    parameter int unsigned SCORE_LIMIT = 15,
    parameter int unsigned WIN_BY      = 2,
    parameter int unsigned SCORE_CAP   = 20,
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned PLAYER_W    = player_w_for(N_PLAYERS)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         new_game,
    input  logic                         point_valid,
    input  logic [PLAYER_W-1:0]          point_player,
    output logic [N_PLAYERS*SCORE_W-1:0] scores,
    output logic [1:0]                   phase,
    output logic                         serve_ready,
    output logic                         game_over,
    output logic                         game_over_pulse,
    output logic [PLAYER_W-1:0]          winner,
    output logic                         point_ignored
);

    localparam int unsigned CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
    localparam int unsigned EXT_W = SCORE_W + 1;

    match_phase_t                 phase_q, phase_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [N_PLAYERS*SCORE_W-1:0] scores_q, scores_d;
    logic [PLAYER_W-1:0]          winner_q, winner_d;
    logic                         serve_ready_q, serve_ready_d;
    logic                         game_over_q, game_over_d;
    logic                         pulse_q, pulse_d;
    logic                         ignored_q, ignored_d;

    int unsigned                  p_idx;
    logic                         player_ok;
    logic                         score_hit;
    logic [SCORE_W-1:0]           cur_score;
    logic [SCORE_W-1:0]           opp_best;
    logic [EXT_W-1:0]             s_inc;
    logic [EXT_W-1:0]             opp_ext;
    logic [EXT_W-1:0]             margin;
    logic                         win;

    assign p_idx     = 32'(point_player);
    assign player_ok = (p_idx < N_PLAYERS);
    // new_game wins over a coincident point, which is then dropped silently
    assign score_hit = (phase_q == PLAY) && point_valid && !new_game && player_ok;

    always_comb begin
        cur_score = '0;
        if (player_ok) cur_score = scores_q[p_idx*SCORE_W +: SCORE_W];
    end

    best_opponent #(
        .N_PLAYERS (N_PLAYERS),
        .SCORE_W   (SCORE_W),
        .PLAYER_W  (PLAYER_W)
    ) u_best_opponent (
        .scores  (scores_q),
        .exclude (point_player),
        .best    (opp_best)
    );

    // Margin in one extra bit, clamped at 0 so it can never wrap
    assign s_inc   = {1'b0, cur_score} + EXT_W'(1);
    assign opp_ext = {1'b0, opp_best};
    assign margin  = (s_inc > opp_ext) ? (s_inc - opp_ext) : '0;
    assign win     = ((s_inc >= EXT_W'(SCORE_LIMIT)) && (margin >= EXT_W'(WIN_BY)))
                     || (s_inc == EXT_W'(SCORE_CAP));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q       <= IDLE;
            cnt_q         <= '0;
            scores_q      <= '0;
            winner_q      <= '0;
            serve_ready_q <= 1'b0;
            game_over_q   <= 1'b0;
            pulse_q       <= 1'b0;
            ignored_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            scores_q      <= scores_d;
            winner_q      <= winner_d;
            serve_ready_q <= serve_ready_d;
            game_over_q   <= game_over_d;
            pulse_q       <= pulse_d;
            ignored_q     <= ignored_d;
        end
    end

    // Next-state logic: phase and serve countdown
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (new_game) begin
            phase_d = SERVE_WAIT;
            cnt_d   = CNT_W'(SERVE_DELAY);
        end else begin
            unique case (phase_q)
                SERVE_WAIT: begin
                    if (cnt_q == '0) phase_d = PLAY;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                PLAY: begin
                    if (score_hit) begin
                        if (win) begin
                            phase_d = OVER;
                        end else begin
                            phase_d = SERVE_WAIT;
                            cnt_d   = CNT_W'(SERVE_DELAY);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic: scoreboard, winner and status flags, all registered.
    // Flags are decoded from the next phase so they line up with phase.
    always_comb begin
        scores_d      = scores_q;
        winner_d      = winner_q;
        pulse_d       = 1'b0;
        ignored_d     = 1'b0;
        if (new_game) begin
            scores_d = '0;
            winner_d = '0;
        end else begin
            if (score_hit) begin
                scores_d[p_idx*SCORE_W +: SCORE_W] = s_inc[SCORE_W-1:0];
                if (win) begin
                    winner_d = point_player;
                    pulse_d  = 1'b1;
                end
            end
            ignored_d = point_valid && !score_hit;
        end
        serve_ready_d = (phase_d == PLAY);
        game_over_d   = (phase_d == OVER);
    end

    assign scores          = scores_q;
    assign phase           = phase_q;
    assign serve_ready     = serve_ready_q;
    assign game_over       = game_over_q;
    assign game_over_pulse = pulse_q;
    assign winner          = winner_q;
    assign point_ignored   = ignored_q;

endmodule
